sel_code_scanner: RTL and testbench

SEL_CODE_SCANNER -- requirements
Module: sel_code_scanner

---
 rtl/sel_code_scanner.sv | 127 ++++++++++++
 tb/tb_sel_code_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_code_scanner.sv
// Select-code scanner: latches a 2-bit code, compares it against 0..3 one step per cycle.
// Optional macro SCAN_EARLY_EXIT_EN ends the scan on the first matching constant.
module sel_code_scanner (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_code,
   input  logic       in_a,
   input  logic       in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] match_vec,
   output logic       mux_sel,
   output logic       out_data,
   output logic [2:0] scan_cnt,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t     r_state;
   state_t     w_next;

   logic [1:0] r_code;
   logic       r_a;
   logic       r_b;
   logic [3:0] r_match;
   logic [1:0] r_idx;
   logic [2:0] r_cnt;

   logic       w_accept;
   logic       w_xfer;
   logic       w_hit;
   logic       w_last;

   assign w_accept = in_valid && (r_state == S_IDLE);
   assign w_xfer   = out_ready && (r_state == S_DONE);
   assign w_hit    = (r_code == r_idx);

`ifdef SCAN_EARLY_EXIT_EN
   assign w_last = w_hit || (r_idx == 2'd3);
`else
   assign w_last = (r_idx == 2'd3);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_SCAN;
            end
         end
         S_SCAN: begin
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (w_xfer) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Result registers stay put outside SCAN so DONE holds them for the consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_code  <= 2'd0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_match <= 4'd0;
         r_idx   <= 2'd0;
         r_cnt   <= 3'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_code  <= in_code;
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_match <= 4'd0;
                  r_idx   <= 2'd0;
                  r_cnt   <= 3'd0;
               end
            end
            S_SCAN: begin
               if (w_hit) begin
                  r_match[r_idx] <= 1'b1;
               end
               r_cnt <= r_cnt + 3'd1;
               if (r_idx != 2'd3) begin
                  r_idx <= r_idx + 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_SCAN) || (r_state == S_DONE);
   assign match_vec = r_match;
   assign mux_sel   = r_match[0];
   assign out_data  = r_match[0] ? r_a : r_b;
   assign scan_cnt  = r_cnt;

endmodule

// File: tb/tb_sel_code_scanner.sv
// Bench for sel_code_scanner: vector table, directed reset/hold cases, random model check.
// Expectations follow SCAN_EARLY_EXIT_EN when the macro is defined.
module tb_sel_code_scanner;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_code;
   logic       in_a;
   logic       in_b;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] match_vec;
   logic       mux_sel;
   logic       out_data;
   logic [2:0] scan_cnt;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;

   sel_code_scanner dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .match_vec(match_vec),
      .mux_sel  (mux_sel),
      .out_data (out_data),
      .scan_cnt (scan_cnt),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] code;
      logic       a;
      logic       b;
      logic [3:0] exp_match;
      logic       exp_data;
      int         cnt_full;
      int         cnt_early;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [1:0] c, input logic a, input logic b);
      in_valid = 1'b1;
      in_code  = c;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
      in_code  = 2'($urandom);
      in_a     = 1'($urandom);
      in_b     = 1'($urandom);
   endtask

   // Full transaction from IDLE: accept, scan, hold in DONE, then transfer.
   task automatic txn(input string nm, input logic [1:0] c, input logic a,
                      input logic b, input int hold, input logic [3:0] em,
                      input int ecnt, input logic ed);
      int  n;
      bit  got;
      n   = 0;
      got = 0;
      chk({nm, ".in_ready_idle"}, int'(in_ready), 1);
      accept(c, a, b);
      while (n < 8 && !got) begin
         out_ready = 1'($urandom);
         in_valid  = 1'($urandom);
         in_code   = 2'($urandom);
         tick();
         n++;
         if (out_valid) got = 1;
      end
      in_valid = 1'b0;
      if (!got) begin
         chk({nm, ".timeout"}, 0, 1);
         out_ready = 1'b0;
         return;
      end
      chk({nm, ".latency"}, n, ecnt);
      chk({nm, ".match"}, int'(match_vec), int'(em));
      chk({nm, ".mux_sel"}, int'(mux_sel), int'(em[0]));
      chk({nm, ".data"}, int'(out_data), int'(ed));
      chk({nm, ".cnt"}, int'(scan_cnt), ecnt);
      chk({nm, ".in_ready_done"}, int'(in_ready), 0);
      chk({nm, ".busy_done"}, int'(busy), 1);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         in_code   = 2'd1;
         tick();
         chk({nm, ".hold_valid"}, int'(out_valid), 1);
         chk({nm, ".hold_match"}, int'(match_vec), int'(em));
         chk({nm, ".hold_data"}, int'(out_data), int'(ed));
         chk({nm, ".hold_cnt"}, int'(scan_cnt), ecnt);
         chk({nm, ".hold_rdy"}, int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, ".post_valid"}, int'(out_valid), 0);
      chk({nm, ".post_rdy"}, int'(in_ready), 1);
      chk({nm, ".post_busy"}, int'(busy), 0);
   endtask

   function automatic int exp_cnt_of(input logic [1:0] c);
`ifdef SCAN_EARLY_EXIT_EN
      return int'(c) + 1;
`else
      return 4;
`endif
   endfunction

   task automatic chk_zero(input string nm);
      chk({nm, ".rdy"}, int'(in_ready), 1);
      chk({nm, ".valid"}, int'(out_valid), 0);
      chk({nm, ".match"}, int'(match_vec), 0);
      chk({nm, ".mux"}, int'(mux_sel), 0);
      chk({nm, ".data"}, int'(out_data), 0);
      chk({nm, ".cnt"}, int'(scan_cnt), 0);
      chk({nm, ".busy"}, int'(busy), 0);
   endtask

   initial begin
      int       ecnt;
      bit       got;
      logic [1:0] rc;
      logic     ra;
      logic     rb;

      vecs[0] = '{2'd2, 1'b1, 1'b0, 4'b0100, 1'b0, 4, 3};
      vecs[1] = '{2'd0, 1'b1, 1'b0, 4'b0001, 1'b1, 4, 1};
      vecs[2] = '{2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 4, 2};
      vecs[3] = '{2'd3, 1'b1, 1'b1, 4'b1000, 1'b1, 4, 4};
      vecs[4] = '{2'd0, 1'b0, 1'b1, 4'b0001, 1'b0, 4, 1};
      vecs[5] = '{2'd3, 1'b1, 1'b0, 4'b1000, 1'b0, 4, 4};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = 2'd0;
      in_a      = 1'b0;
      in_b      = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_zero("reset");

      foreach (vecs[i]) begin
`ifdef SCAN_EARLY_EXIT_EN
         ecnt = vecs[i].cnt_early;
`else
         ecnt = vecs[i].cnt_full;
`endif
         txn($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
             (i == 3) ? 5 : 0, vecs[i].exp_match, ecnt, vecs[i].exp_data);
      end

      // Back-to-back codes 0..3 with zero hold: one IDLE cycle between results.
      for (int k = 0; k < 4; k++) begin
         txn($sformatf("b2b%0d", k), 2'(k), 1'b1, 1'b0, 0,
             4'(1 << k), exp_cnt_of(2'(k)), (k == 0));
      end

      // Reset sampled at E2 of a code-3 scan aborts the result.
      accept(2'd3, 1'b1, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("rst_scan");
      got = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) got = 1;
      end
      chk("rst_scan.no_valid", int'(got), 0);
      txn("after_rst", 2'd1, 1'b0, 1'b1, 1, 4'b0010, exp_cnt_of(2'd1), 1'b1);

      // Reset beats a simultaneous accept.
      in_valid = 1'b1;
      in_code  = 2'd2;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk_zero("rst_acc");

      // Reset beats a simultaneous transfer in DONE.
      accept(2'd0, 1'b1, 1'b0);
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (out_valid) got = 1;
      end
      chk("rst_done.reach", int'(got), 1);
      rst       = 1'b1;
      out_ready = 1'b1;
      tick();
      rst       = 1'b0;
      out_ready = 1'b0;
      chk_zero("rst_done");

      // Random transactions against a rule-level model.
      for (int t = 0; t < 40; t++) begin
         rc = 2'($urandom);
         ra = 1'($urandom);
         rb = 1'($urandom);
         txn($sformatf("rnd%0d", t), rc, ra, rb, $urandom_range(0, 3),
             4'(1 << rc), exp_cnt_of(rc), (rc == 2'd0) ? ra : rb);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
